// File: rtl/pixel_cfg_pkg.sv
// pixel_cfg_pkg
// Shared definitions for the pixel configuration chain: the serializer state
// encoding and the default word width, serial half-period and latch length
// used by the serializer, the chain model and the pixel-config top level.
package pixel_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } cfg_ser_state_t;

  localparam int CFG_DATA_W    = 32;
  localparam int CFG_SCLK_HALF = 2;
  localparam int CFG_LOAD_LEN  = 4;

endpackage

// File: rtl/pixel_cfg_phase_cnt.sv
// pixel_cfg_phase_cnt
// Reloadable down-counter with a terminal-count flag. Loading N-1 on state
// entry makes tc rise in the N-th cycle of that state, so a state lasts
// exactly N cycles. The counter stops at zero instead of wrapping.
// Ports:
//   clkin    - block clock
//   rst      - synchronous active-high reset (count cleared)
//   load     - reload the counter with load_val this cycle
//   load_val - reload value (cycles in state minus one)
//   tc       - high while the count is zero
module pixel_cfg_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/pixel_cfg_serializer.sv
// pixel_cfg_serializer
// Parallel-to-serial driver for the pixel configuration chain. Words arrive
// over a valid/ready handshake and are shifted out MSB-first on a generated
// serial clock; after the last word of a frame a latch strobe is issued.
// Ports:
//   clkin    - block clock (divided pixel-config clock)
//   rst      - synchronous active-high reset, aborts any frame in progress
//   in_valid - in_data/in_last valid
//   in_ready - block can accept a word (only in IDLE)
//   in_data  - configuration word, bit DATA_W-1 shifted first
//   in_last  - word is the final word of the frame
//   sclk     - serial clock, the chain samples on its rising edge
//   sdata    - serial data, changes only on entry to SHIFT_LO
//   sload    - chain latch strobe, LOAD_LEN cycles
//   busy     - frame in progress
//   done     - one-cycle pulse at end of frame
module pixel_cfg_serializer
  import pixel_cfg_pkg::*;
#(
  parameter int DATA_W    = CFG_DATA_W,
  parameter int SCLK_HALF = CFG_SCLK_HALF,
  parameter int LOAD_LEN  = CFG_LOAD_LEN
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              sclk,
  output logic              sdata,
  output logic              sload,
  output logic              busy,
  output logic              done
);

  localparam int PH_W = $clog2(SCLK_HALF + 1);
  localparam int BC_W = $clog2(DATA_W);
  localparam int LD_W = $clog2(LOAD_LEN + 1);

  cfg_ser_state_t state, next_state;

  logic [DATA_W-1:0] shreg, shreg_next;
  logic [BC_W-1:0]   bitcnt, bitcnt_next;
  logic              last_q, last_next;
  logic              busy_next;
  logic              ph_load, ph_tc;
  logic              ld_load, ld_tc;

  // One counter times both shift half-periods; it is reloaded on every
  // entry into SHIFT_LO or SHIFT_HI.
  pixel_cfg_phase_cnt #(.W(PH_W)) u_phase_cnt (
    .clkin    (clkin),
    .rst      (rst),
    .load     (ph_load),
    .load_val (PH_W'(SCLK_HALF - 1)),
    .tc       (ph_tc)
  );

  pixel_cfg_phase_cnt #(.W(LD_W)) u_load_cnt (
    .clkin    (clkin),
    .rst      (rst),
    .load     (ld_load),
    .load_val (LD_W'(LOAD_LEN - 1)),
    .tc       (ld_tc)
  );

  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    shreg_next  = shreg;
    bitcnt_next = bitcnt;
    last_next   = last_q;
    busy_next   = busy;
    ph_load     = 1'b0;
    ld_load     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state  = SHIFT_LO;
          shreg_next  = in_data;
          bitcnt_next = BC_W'(DATA_W - 1);
          last_next   = in_last;
          busy_next   = 1'b1;
          ph_load     = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (ph_tc) begin
          next_state = SHIFT_HI;
          ph_load    = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (ph_tc) begin
          if (bitcnt != '0) begin
            shreg_next  = {shreg[DATA_W-2:0], 1'b0};
            bitcnt_next = bitcnt - BC_W'(1);
            next_state  = SHIFT_LO;
            ph_load     = 1'b1;
          end else if (last_q) begin
            next_state = LOAD;
            ld_load    = 1'b1;
          end else begin
            // Mid-frame word boundary: wait in IDLE with busy still set.
            next_state = IDLE;
          end
        end
      end
      LOAD: begin
        if (ld_tc) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so that each output value
  // lines up exactly with the cycles spent in the corresponding state.
  always_ff @(posedge clkin) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
      last_q <= 1'b0;
      busy   <= 1'b0;
      sclk   <= 1'b0;
      sdata  <= 1'b0;
      sload  <= 1'b0;
      done   <= 1'b0;
    end else begin
      shreg  <= shreg_next;
      bitcnt <= bitcnt_next;
      last_q <= last_next;
      busy   <= busy_next;
      sclk   <= (next_state == SHIFT_HI);
      sdata  <= ((next_state == SHIFT_LO) || (next_state == SHIFT_HI)) ?
                shreg_next[DATA_W-1] : 1'b0;
      sload  <= (next_state == LOAD);
      done   <= (next_state == DONE);
    end
  end

  assign in_ready = (state == IDLE) & ~rst;

endmodule

// File: tb/tb_pixel_cfg_serializer.sv
// tb_pixel_cfg_serializer
// Bench for pixel_cfg_serializer. Instance A uses DATA_W=8, SCLK_HALF=2,
// LOAD_LEN=4; instance B uses DATA_W=32, SCLK_HALF=1, LOAD_LEN=4. Expected
// words are queued when issued; a monitor rebuilds words from sdata sampled
// at rising sclk edges and compares them against the queue.
module tb_pixel_cfg_serializer;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic rst;

  logic       a_in_valid, a_in_ready, a_in_last;
  logic [7:0] a_in_data;
  logic       a_sclk, a_sdata, a_sload, a_busy, a_done;

  logic        b_in_valid, b_in_ready, b_in_last;
  logic [31:0] b_in_data;
  logic        b_sclk, b_sdata, b_sload, b_busy, b_done;

  pixel_cfg_serializer #(.DATA_W(8), .SCLK_HALF(2), .LOAD_LEN(4)) dut_a (
    .clkin    (clkin),
    .rst      (rst),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (a_in_data),
    .in_last  (a_in_last),
    .sclk     (a_sclk),
    .sdata    (a_sdata),
    .sload    (a_sload),
    .busy     (a_busy),
    .done     (a_done)
  );

  pixel_cfg_serializer #(.DATA_W(32), .SCLK_HALF(1), .LOAD_LEN(4)) dut_b (
    .clkin    (clkin),
    .rst      (rst),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .in_last  (b_in_last),
    .sclk     (b_sclk),
    .sdata    (b_sdata),
    .sload    (b_sload),
    .busy     (b_busy),
    .done     (b_done)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        aExpQ[$];
  exp_t        aHead;
  logic [31:0] bExpQ[$];
  logic [31:0] bHead;

  logic        aPrevSclk = 1'b0, aPrevSload = 1'b0, bPrevSclk = 1'b0;
  logic [7:0]  aWord = '0;
  logic [31:0] bWord = '0;
  int          aBits = 0, bBits = 0;
  logic        aLastPopped = 1'b0;
  int          aSclkRises = 0, aSloadRises = 0, aDoneCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: rebuild serial words and check them against the queues.
  always @(negedge clkin) begin
    if (rst) begin
      aBits = 0;
      bBits = 0;
    end else begin
      if (a_sclk && !aPrevSclk) begin
        aSclkRises++;
        aWord = {aWord[6:0], a_sdata};
        aBits++;
        if (aBits == 8) begin
          aBits = 0;
          if (aExpQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL aUnexpectedWord: got 0x%0h, expected none", aWord);
          end else begin
            aHead = aExpQ.pop_front();
            checkOutput("aWord", 64'(aWord), 64'(aHead.data));
            aLastPopped = aHead.last;
          end
        end
      end
      if (a_sload && !aPrevSload) begin
        aSloadRises++;
        checkOutput("aSloadAfterLast", {62'd0, aBits == 0, aLastPopped}, 64'd3);
      end
      if (a_done) aDoneCount++;
      if (b_sclk && !bPrevSclk) begin
        bWord = {bWord[30:0], b_sdata};
        bBits++;
        if (bBits == 32) begin
          bBits = 0;
          if (bExpQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL bUnexpectedWord: got 0x%0h, expected none", bWord);
          end else begin
            bHead = bExpQ.pop_front();
            checkOutput("bWord", 64'(bWord), 64'(bHead));
          end
        end
      end
    end
    aPrevSclk  = a_sclk;
    aPrevSload = a_sload;
    bPrevSclk  = b_sclk;
  end

  task automatic sendA(input logic [7:0] d, input logic l, input bit dropAfter);
    int n;
    aExpQ.push_back('{data: d, last: l});
    a_in_data  = d;
    a_in_last  = l;
    a_in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 500) begin
      @(negedge clkin);
      n++;
    end
    if (n >= 500) checkOutput("aAcceptTimeout", 64'd0, 64'd1);
    @(posedge clkin);
    #1;
    if (dropAfter) a_in_valid = 1'b0;
  endtask

  task automatic waitDoneA(input int bound);
    int n;
    n = 0;
    while (!a_done && n < bound) begin
      @(negedge clkin);
      n++;
    end
    checkOutput("aDoneSeen", 64'(a_done), 64'd1);
    @(negedge clkin);
  endtask

  task automatic applyStimulus();
    logic [7:0]  w;
    logic [31:0] wb;
    int          r0, l0, d0, n;
    logic        eSclk, eSdata, eSload, eDone, eBusy, eReady;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clkin);
    checkOutput("readyDuringReset", {62'd0, a_in_ready, b_in_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clkin);
    checkOutput("resetStateA", {58'd0, a_sclk, a_sdata, a_sload, a_done, a_busy, a_in_ready}, 64'd1);
    checkOutput("resetStateB", {58'd0, b_sclk, b_sdata, b_sload, b_done, b_busy, b_in_ready}, 64'd1);

    // Single word 0xA5, cycle-exact timing
    $display("[TB] single word");
    l0 = aSloadRises;
    w  = 8'hA5;
    sendA(w, 1'b1, 1'b1);
    for (int k = 1; k <= 38; k++) begin
      @(negedge clkin);
      eSclk  = (k <= 32) && (((k - 1) % 4) >= 2);
      eSdata = (k <= 32) ? w[7 - ((k - 1) / 4)] : 1'b0;
      eSload = (k >= 33) && (k <= 36);
      eDone  = (k == 37);
      eBusy  = (k <= 37);
      eReady = (k >= 38);
      checkOutput($sformatf("t1Cycle%0d", k),
                  {58'd0, a_sclk, a_sdata, a_sload, a_done, a_busy, a_in_ready},
                  {58'd0, eSclk, eSdata, eSload, eDone, eBusy, eReady});
    end
    checkOutput("t1SloadCount", 64'(aSloadRises - l0), 64'd1);

    // Back-to-back frame with in_valid held
    $display("[TB] back-to-back");
    r0 = aSclkRises;
    l0 = aSloadRises;
    sendA(8'h3C, 1'b0, 1'b0);
    aExpQ.push_back('{data: 8'hF0, last: 1'b1});
    a_in_data = 8'hF0;
    a_in_last = 1'b1;
    n = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clkin);
      if (a_in_ready) n++;
      if (k >= 32) checkOutput($sformatf("t2Ready%0d", k), 64'(a_in_ready), 64'(k == 33));
    end
    checkOutput("t2ReadyCycles", 64'(n), 64'd1);
    @(posedge clkin);
    #1;
    a_in_valid = 1'b0;
    @(negedge clkin);
    checkOutput("t2SecondAccepted", {62'd0, a_busy, a_in_ready}, 64'd2);
    waitDoneA(100);
    checkOutput("t2SclkPulses", 64'(aSclkRises - r0), 64'd16);
    checkOutput("t2SloadCount", 64'(aSloadRises - l0), 64'd1);

    // Gap of 10 cycles between two words of one frame
    $display("[TB] gap between words");
    sendA(8'h5A, 1'b0, 1'b1);
    n = 0;
    while (!a_in_ready && n < 100) begin
      @(negedge clkin);
      n++;
    end
    for (int g = 0; g < 10; g++) begin
      checkOutput($sformatf("t3Gap%0d", g), {60'd0, a_sclk, a_sdata, a_busy, a_sload}, 64'd2);
      @(negedge clkin);
    end
    sendA(8'h69, 1'b1, 1'b1);
    waitDoneA(100);

    // Reset after the 3rd rising sclk edge
    $display("[TB] reset mid-shift");
    l0 = aSloadRises;
    d0 = aDoneCount;
    r0 = aSclkRises;
    sendA(8'hC3, 1'b1, 1'b1);
    n = 0;
    while ((aSclkRises - r0) < 3 && n < 200) begin
      @(negedge clkin);
      #1;
      n++;
    end
    checkOutput("t4ThirdEdge", 64'(aSclkRises - r0), 64'd3);
    rst = 1'b1;
    @(posedge clkin);
    #1;
    checkOutput("t4AfterReset", {59'd0, a_sclk, a_sdata, a_busy, a_sload, a_done}, 64'd0);
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    aExpQ.delete();
    repeat (6) @(negedge clkin);
    checkOutput("t4NoSload", 64'(aSloadRises - l0), 64'd0);
    checkOutput("t4NoDone", 64'(aDoneCount - d0), 64'd0);
    sendA(8'h81, 1'b1, 1'b1);
    waitDoneA(100);
    checkOutput("t4SloadAfter", 64'(aSloadRises - l0), 64'd1);

    // Backpressure during LOAD
    $display("[TB] backpressure");
    sendA(8'h12, 1'b1, 1'b1);
    n = 0;
    while (!a_sload && n < 100) begin
      @(negedge clkin);
      n++;
    end
    checkOutput("t5SloadSeen", 64'(a_sload), 64'd1);
    aExpQ.push_back('{data: 8'h34, last: 1'b1});
    a_in_data  = 8'h34;
    a_in_last  = 1'b1;
    a_in_valid = 1'b1;
    n = 0;
    while (!a_done && n < 20) begin
      checkOutput($sformatf("t5HeldOff%0d", n), 64'(a_in_ready), 64'd0);
      @(negedge clkin);
      n++;
    end
    checkOutput("t5ReadyInDone", {62'd0, a_done, a_in_ready}, 64'd2);
    @(negedge clkin);
    checkOutput("t5FirstIdle", {61'd0, a_in_ready, a_busy, a_done}, 64'd4);
    @(posedge clkin);
    #1;
    a_in_valid = 1'b0;
    checkOutput("t5Accepted", {61'd0, a_busy, a_sclk, a_in_ready}, 64'd4);
    waitDoneA(100);

    // Parameter sweep: 32-bit word, SCLK_HALF=1
    $display("[TB] 32-bit sweep");
    wb = 32'hDEADBEEF;
    bExpQ.push_back(wb);
    b_in_data  = wb;
    b_in_last  = 1'b1;
    b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 100) begin
      @(negedge clkin);
      n++;
    end
    @(posedge clkin);
    #1;
    b_in_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clkin);
      checkOutput($sformatf("t6Cycle%0d", k), {62'd0, b_sclk, b_sdata},
                  {62'd0, ((k - 1) % 2) == 1, wb[31 - ((k - 1) / 2)]});
    end
    @(negedge clkin);
    checkOutput("t6SloadAfterShift", {62'd0, b_sload, b_sclk}, 64'd2);
    n = 0;
    while (!b_done && n < 20) begin
      @(negedge clkin);
      n++;
    end
    checkOutput("t6Done", 64'(b_done), 64'd1);

    repeat (4) @(negedge clkin);
    checkOutput("aQueueEmpty", 64'(aExpQ.size()), 64'd0);
    checkOutput("bQueueEmpty", 64'(bExpQ.size()), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    a_in_valid = 1'b0;
    a_in_data  = '0;
    a_in_last  = 1'b0;
    b_in_valid = 1'b0;
    b_in_data  = '0;
    b_in_last  = 1'b0;
    applyStimulus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
